bandgap_seq_ctrl: RTL and testbench
===================================

// Module: bandgap_seq_ctrl
// PURPOSE
//  Sequenced, trimmable, multi-consumer behavioural bandgap model for mixed-signal sims.
//  Successor to the single-EN bandgap model. Adds:
//   - a clocked power-up FSM with startup and settle timers;
//   - a digital trim code;
//   - NCH independent enable requesters with per-channel ready;
//   - power-down hysteresis.
//  Drives real-valued VBGP/VBGVTN to the analog consumers (ADC, DAC, comparators).
// PARAMETERS
//  NCH          4      number of enable requesters
//  TRIM_W       4      trim code width; code 2**(TRIM_W-1) = nominal
//  STARTUP_CYC  16     clk cycles in STARTUP (outputs held 0.0)
//  SETTLE_CYC   32     clk cycles in SETTLE (outputs at target, not yet ready)
//  OFF_HOLD     8      clk cycles with no request before core shuts down
//  VBGP_NOM     1.235  real, VBGP at nominal trim (V)
//  VBGVTN_NOM   1.018  real, VBGVTN at nominal trim (V)
//  TRIM_STEP    0.002  real, volts per trim LSB, applied to both outputs
// PORTS
//  clk       in   1       system clock
//  resetn    in   1       asynchronous, active-low reset
//  en_req    in   NCH     per-channel enable request, level
//  trim      in   TRIM_W  trim code, unsigned
//  trim_load in   1       1-cycle strobe: capture trim
//  vdda_ok   in   1       analog supply good; low forces OFF
//  VBGP      out  real    bandgap output (V)
//  VBGVTN    out  real    VTN-referenced output (V)
//  ready     out  NCH     ready[i] = core_ready & en_req[i]
//  core_on   out  1       core powered (any state except OFF)
//  state     out  2       FSM state: 0 OFF, 1 STARTUP, 2 SETTLE, 3 READY
// BEHAVIOUR
//  Reset (resetn=0, async): state=OFF, counters=0, trim_q=2**(TRIM_W-1).
//   Outputs at reset: VBGP=VBGVTN=0.0, ready=0, core_on=0.
//  any_req = |en_req. Target voltage: VBGP_NOM + (trim_q - 2**(TRIM_W-1))*TRIM_STEP; same form for VBGVTN.
//  OFF:
//   - any_req & vdda_ok -> STARTUP; counter cleared; trim_q <= trim in the same cycle.
//  STARTUP:
//   - Outputs 0.0.
//   - After STARTUP_CYC cycles -> SETTLE.
//   - If !any_req, return to OFF immediately (no hold).
//  SETTLE:
//   - Outputs at target.
//   - After SETTLE_CYC cycles -> READY.
//   - If !any_req, go to OFF.
//  READY:
//   - core_ready=1.
//   - If any_req==0 for OFF_HOLD consecutive cycles -> OFF.
//   - A request reasserting within the hold stays READY; no re-settle, and the hold counter clears.
//  trim_load:
//   - READY: trim_q <= trim, go to SETTLE, counter cleared, ready drops the next cycle.
//   - SETTLE: trim_q updated, settle counter restarts.
//   - STARTUP: trim_q updated, no timer effect.
//   - OFF: ignored.
//  vdda_ok=0 in any state: next cycle OFF, outputs 0.0, ready=0. Highest priority.
//   - vdda_ok=0 is sampled synchronously; it is not an async clear.
//  Priority per cycle: vdda_ok low > all-request drop > trim_load > timer expiry.
//  Timing and latency:
//   - Outputs update on clk edges only.
//   - Latency from request to ready = 1 + STARTUP_CYC + SETTLE_CYC cycles.
//   - ready is combinational from the state register and en_req.
//  Counter:
//   - One shared counter, width clog2(max(STARTUP_CYC, SETTLE_CYC, OFF_HOLD)+1).
//   - Saturates; never wraps.
//  Asserting resetn mid-ramp: outputs 0.0 at once, no glitch to target.
// STRUCTURE
//  Shared package bgp_pkg: state enum encodings (OFF/STARTUP/SETTLE/READY) and the nominal-trim constant.
//  Sub-module bgp_seq_timer: load/clear/expire counter, reused for all three timers.
//  Real-value output mapping stays in the top; it is the only non-synthesisable part.
// TESTING
//  1. en_req=0001, vdda_ok=1, default params -> core_on next cycle.
//     VBGP=0.0 for 16 cycles, then 1.235. ready=0001 at cycle 49, state=3.
//  2. In READY, trim=4'hA + trim_load -> VBGP=1.239, VBGVTN=1.022.
//     ready=0 for 32 cycles, then back to 0001.
//  3. Drop en_req for 5 cycles, re-raise -> stays READY, ready returns immediately.
//     Drop for 8 cycles -> OFF, VBGP=0.0.
//  4. vdda_ok=0 during SETTLE -> OFF next cycle, outputs 0.0.
//     vdda_ok=1 with request held -> full startup again.
//  5. en_req=0101 -> ready=0101. Drop ch0 -> ready=0100, no re-settle, core stays on.
//  6. resetn low mid-STARTUP and mid-READY -> async OFF, outputs 0.0, trim_q at nominal.

Source files
------------

// File: rtl/bgp_pkg.sv
// Shared definitions for the sequenced bandgap controller: FSM state
// encodings, nominal-trim constant and small elaboration-time helpers.
package bgp_pkg;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_STARTUP = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_READY   = 2'd3
  } bgp_state_e;

  // Default trim width and the code that yields the nominal output voltage.
  localparam int TRIM_W_DEF   = 4;
  localparam int TRIM_NOM_DEF = 1 << (TRIM_W_DEF - 1);

  // Nominal trim code for an arbitrary trim width (mid-scale).
  function automatic int trim_nominal(input int trim_w);
    return 1 << (trim_w - 1);
  endfunction

  // Largest of three timer lengths; sizes the shared counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bgp_seq_timer.sv
// Shared cycle timer: synchronous clear, saturating increment and an
// expire flag raised when the count equals the selected limit.
module bgp_seq_timer #(
  parameter int W = 6
) (
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] limit_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up but stop at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, cleared asynchronously by reset.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == limit_i);

endmodule

// File: rtl/bandgap_seq_ctrl.sv
// Sequenced, trimmable, multi-consumer bandgap model. A clocked power-up
// FSM walks OFF -> STARTUP -> SETTLE -> READY, with power-down hysteresis,
// and drives real-valued VBGP/VBGVTN for mixed-signal simulation.
module bandgap_seq_ctrl
  import bgp_pkg::*;
#(
  parameter int  NCH         = 4,
  parameter int  TRIM_W      = TRIM_W_DEF,
  parameter int  STARTUP_CYC = 16,
  parameter int  SETTLE_CYC  = 32,
  parameter int  OFF_HOLD    = 8,
  parameter real VBGP_NOM    = 1.235,
  parameter real VBGVTN_NOM  = 1.018,
  parameter real TRIM_STEP   = 0.002
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NCH-1:0]    en_req,
  input  logic [TRIM_W-1:0] trim,
  input  logic              trim_load,
  input  logic              vdda_ok,
  output real               VBGP,
  output real               VBGVTN,
  output logic [NCH-1:0]    ready,
  output logic              core_on,
  output logic [1:0]        state
);

  localparam int CNT_W    = $clog2(max3(STARTUP_CYC, SETTLE_CYC, OFF_HOLD) + 1);
  localparam int TRIM_NOM = trim_nominal(TRIM_W);

  bgp_state_e        state_q;
  logic [TRIM_W-1:0] trim_q;
  logic              any_req_s;
  logic              tmr_clr_s;
  logic              tmr_inc_s;
  logic [CNT_W-1:0]  tmr_limit_s;
  logic              tmr_expire_s;
  logic              out_on_s;
  real               trim_ofs_s;

  assign any_req_s = |en_req;

  // Timer control: select the limit for the current phase and decide
  // whether the shared counter clears or advances this cycle.
  always_comb begin
    tmr_clr_s   = 1'b0;
    tmr_inc_s   = 1'b0;
    tmr_limit_s = CNT_W'(STARTUP_CYC - 1);
    case (state_q)
      ST_OFF: begin
        tmr_clr_s = 1'b1;
      end
      ST_STARTUP: begin
        tmr_limit_s = CNT_W'(STARTUP_CYC - 1);
        if (!vdda_ok || !any_req_s || tmr_expire_s) begin
          tmr_clr_s = 1'b1;
        end else begin
          tmr_inc_s = 1'b1;
        end
      end
      ST_SETTLE: begin
        tmr_limit_s = CNT_W'(SETTLE_CYC - 1);
        if (!vdda_ok || !any_req_s || trim_load || tmr_expire_s) begin
          tmr_clr_s = 1'b1;
        end else begin
          tmr_inc_s = 1'b1;
        end
      end
      ST_READY: begin
        // In READY the counter measures consecutive request-free cycles.
        tmr_limit_s = CNT_W'(OFF_HOLD - 1);
        if (!vdda_ok || any_req_s || tmr_expire_s) begin
          tmr_clr_s = 1'b1;
        end else begin
          tmr_inc_s = 1'b1;
        end
      end
      default: begin
        tmr_clr_s = 1'b1;
      end
    endcase
  end

  bgp_seq_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk_i    (clk),
    .resetn_i (resetn),
    .clr_i    (tmr_clr_s),
    .inc_i    (tmr_inc_s),
    .limit_i  (tmr_limit_s),
    .expire_o (tmr_expire_s)
  );

  // Power-up sequencer and trim capture; supply loss outranks request
  // drop, which outranks trim_load, which outranks timer expiry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_OFF;
      trim_q  <= TRIM_W'(TRIM_NOM);
    end else if (!vdda_ok) begin
      state_q <= ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (any_req_s) begin
            state_q <= ST_STARTUP;
            trim_q  <= trim;
          end
        end
        ST_STARTUP: begin
          if (!any_req_s) begin
            state_q <= ST_OFF;
          end else begin
            if (trim_load) begin
              trim_q <= trim;
            end
            if (tmr_expire_s) begin
              state_q <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (!any_req_s) begin
            state_q <= ST_OFF;
          end else if (trim_load) begin
            trim_q <= trim;
          end else if (tmr_expire_s) begin
            state_q <= ST_READY;
          end
        end
        ST_READY: begin
          if (!any_req_s) begin
            if (tmr_expire_s) begin
              state_q <= ST_OFF;
            end
          end else if (trim_load) begin
            trim_q  <= trim;
            state_q <= ST_SETTLE;
          end
        end
        default: begin
          state_q <= ST_OFF;
        end
      endcase
    end
  end

  assign state    = state_q;
  assign core_on  = (state_q != ST_OFF);
  assign ready    = {NCH{state_q == ST_READY}} & en_req;
  assign out_on_s = (state_q == ST_SETTLE) || (state_q == ST_READY);

  // Analog view: outputs sit at the trimmed target once the core has
  // passed STARTUP, and at 0.0 V otherwise (including during reset).
  always_comb begin
    trim_ofs_s = real'(int'(trim_q) - TRIM_NOM) * TRIM_STEP;
    if (out_on_s) begin
      VBGP   = VBGP_NOM + trim_ofs_s;
      VBGVTN = VBGVTN_NOM + trim_ofs_s;
    end else begin
      VBGP   = 0.0;
      VBGVTN = 0.0;
    end
  end

endmodule

// File: tb/tb_bandgap_seq_ctrl.sv
// Scoreboard bench for bandgap_seq_ctrl: the stimulus process queues the
// expected response for a given cycle, the monitor compares on negedges.
module tb_bandgap_seq_ctrl;

  localparam logic [1:0] S_OFF = 2'd0;
  localparam logic [1:0] S_STU = 2'd1;
  localparam logic [1:0] S_SET = 2'd2;
  localparam logic [1:0] S_RDY = 2'd3;

  logic       clk;
  logic       resetn;
  logic [3:0] en_req;
  logic [3:0] trim;
  logic       trim_load;
  logic       vdda_ok;
  real        vbgp;
  real        vbgvtn;
  logic [3:0] ready;
  logic       core_on;
  logic [1:0] state;

  typedef struct {
    string      nm;
    int         cyc;
    logic [1:0] st;
    logic [3:0] rd;
    real        vp;
    real        vn;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  bandgap_seq_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .en_req    (en_req),
    .trim      (trim),
    .trim_load (trim_load),
    .vdda_ok   (vdda_ok),
    .VBGP      (vbgp),
    .VBGVTN    (vbgvtn),
    .ready     (ready),
    .core_on   (core_on),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit near(input real a, input real b);
    return ((a - b) < 1.0e-6) && ((b - a) < 1.0e-6);
  endfunction

  // Queue an expectation d posedges from now, sampled at the following negedge.
  task automatic expect_at(input string nm, input int d, input logic [1:0] st,
                           input logic [3:0] rd, input real vp, input real vn);
    exp_t e;
    e.nm  = nm;
    e.cyc = cyc + d;
    e.st  = st;
    e.rd  = rd;
    e.vp  = vp;
    e.vn  = vn;
    q.push_back(e);
  endtask

  // Advance n posedges, then move just past the negedge sample point.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Monitor: compare every expectation due this cycle, flag any overdue one.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        n_chk = n_chk + 1;
        if (state === q[i].st && ready === q[i].rd && core_on === (q[i].st != S_OFF) &&
            near(vbgp, q[i].vp) && near(vbgvtn, q[i].vn)) begin
          n_pass = n_pass + 1;
        end else begin
          $display("FAIL %s cyc=%0d: got state=%0d ready=%b core_on=%b VBGP=%f VBGVTN=%f, want state=%0d ready=%b core_on=%b VBGP=%f VBGVTN=%f",
                   q[i].nm, cyc, state, ready, core_on, vbgp, vbgvtn,
                   q[i].st, q[i].rd, (q[i].st != S_OFF), q[i].vp, q[i].vn);
        end
        q.delete(i);
      end else if (q[i].cyc < cyc) begin
        n_chk = n_chk + 1;
        $display("FAIL %s: expectation for cyc=%0d never sampled", q[i].nm, q[i].cyc);
        q.delete(i);
      end
    end
  end

  initial begin
    resetn    = 1'b0;
    en_req    = 4'b0000;
    trim      = 4'h8;
    trim_load = 1'b0;
    vdda_ok   = 1'b1;
    tick(2);
    expect_at("reset", 1, S_OFF, 4'b0000, 0.0, 0.0);
    tick(1);
    resetn = 1'b1;
    expect_at("idle", 2, S_OFF, 4'b0000, 0.0, 0.0);
    tick(2);

    // 1: power-up from a single request, latency 1 + 16 + 32
    en_req = 4'b0001;
    expect_at("t1_core_on",    1, S_STU, 4'b0000, 0.0,   0.0);
    expect_at("t1_startup_end",16, S_STU, 4'b0000, 0.0,   0.0);
    expect_at("t1_settle",    17, S_SET, 4'b0000, 1.235, 1.018);
    expect_at("t1_settle_end",48, S_SET, 4'b0000, 1.235, 1.018);
    expect_at("t1_ready",     49, S_RDY, 4'b0001, 1.235, 1.018);
    tick(49);

    // 2: retrim in READY forces a fresh 32-cycle settle
    trim = 4'hA;
    trim_load = 1'b1;
    expect_at("t2_reload",   1, S_SET, 4'b0000, 1.239, 1.022);
    expect_at("t2_settle32",32, S_SET, 4'b0000, 1.239, 1.022);
    expect_at("t2_ready",   33, S_RDY, 4'b0001, 1.239, 1.022);
    tick(1);
    trim_load = 1'b0;
    tick(32);

    // 3: power-down hysteresis
    en_req = 4'b0000;
    expect_at("t3_drop1", 1, S_RDY, 4'b0000, 1.239, 1.022);
    expect_at("t3_drop5", 5, S_RDY, 4'b0000, 1.239, 1.022);
    tick(5);
    en_req = 4'b0001;
    expect_at("t3_reraise", 1, S_RDY, 4'b0001, 1.239, 1.022);
    tick(1);
    en_req = 4'b0000;
    expect_at("t3_hold7", 7, S_RDY, 4'b0000, 1.239, 1.022);
    expect_at("t3_off",   8, S_OFF, 4'b0000, 0.0,   0.0);
    tick(8);

    // 4: supply loss during SETTLE, then restart with trim events
    trim = 4'h8;
    en_req = 4'b0001;
    expect_at("t4_start",  1, S_STU, 4'b0000, 0.0,   0.0);
    expect_at("t4_settle",17, S_SET, 4'b0000, 1.235, 1.018);
    tick(20);
    vdda_ok = 1'b0;
    expect_at("t4_vdda_off", 1, S_OFF, 4'b0000, 0.0, 0.0);
    tick(1);
    vdda_ok = 1'b1;
    expect_at("t4_restart", 1, S_STU, 4'b0000, 0.0, 0.0);
    tick(1);
    trim = 4'h9;
    trim_load = 1'b1;
    expect_at("t4_stu_trim",    1, S_STU, 4'b0000, 0.0,   0.0);
    expect_at("t4_settle_trim",16, S_SET, 4'b0000, 1.237, 1.020);
    tick(1);
    trim_load = 1'b0;
    tick(18);
    trim = 4'h8;
    trim_load = 1'b1;
    expect_at("t4_set_trim",     1, S_SET, 4'b0000, 1.235, 1.018);
    expect_at("t4_settle_restart",32, S_SET, 4'b0000, 1.235, 1.018);
    expect_at("t4_ready",        33, S_RDY, 4'b0001, 1.235, 1.018);
    tick(1);
    trim_load = 1'b0;
    tick(32);

    // 5: multiple requesters
    en_req = 4'b0101;
    expect_at("t5_two_ch", 1, S_RDY, 4'b0101, 1.235, 1.018);
    tick(1);
    en_req = 4'b0100;
    expect_at("t5_drop_ch0",   1, S_RDY, 4'b0100, 1.235, 1.018);
    expect_at("t5_still_ready",3, S_RDY, 4'b0100, 1.235, 1.018);
    tick(3);

    // 6: asynchronous reset mid-STARTUP and mid-READY
    en_req = 4'b0000;
    expect_at("t6_off", 8, S_OFF, 4'b0000, 0.0, 0.0);
    tick(8);
    trim = 4'hC;
    en_req = 4'b0001;
    expect_at("t6_stu", 1, S_STU, 4'b0000, 0.0, 0.0);
    tick(5);
    @(posedge clk);
    #1;
    expect_at("t6_rst_stu", 0, S_OFF, 4'b0000, 0.0, 0.0);
    resetn = 1'b0;
    @(negedge clk);
    #1;
    expect_at("t6_rst_hold", 2, S_OFF, 4'b0000, 0.0, 0.0);
    tick(2);
    resetn = 1'b1;
    trim = 4'h6;
    expect_at("t6_stu2",    1, S_STU, 4'b0000, 0.0,   0.0);
    expect_at("t6_settle2",17, S_SET, 4'b0000, 1.231, 1.014);
    expect_at("t6_ready2", 49, S_RDY, 4'b0001, 1.231, 1.014);
    tick(49);
    @(posedge clk);
    #1;
    expect_at("t6_rst_rdy", 0, S_OFF, 4'b0000, 0.0, 0.0);
    resetn = 1'b0;
    @(negedge clk);
    #1;
    en_req = 4'b0000;
    tick(2);
    resetn = 1'b1;
    expect_at("t6_after", 2, S_OFF, 4'b0000, 0.0, 0.0);
    tick(3);

    for (int i = 0; i < q.size(); i++) begin
      n_chk = n_chk + 1;
      $display("FAIL %s: expectation for cyc=%0d left unchecked", q[i].nm, q[i].cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit, got %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
